// File: rtl/g4_table_updater.sv
// Linked-list rule table updater: inserts an entry after a chain predecessor, or
// unlinks and clears the successor of a predecessor, through a registered-read table port.
module g4_table_updater #(
   parameter int                      TABLE_ENTRY_SIZE = 29,
   parameter int                      INDEX_BIT_LEN    = 11,
   parameter int                      ENTRY_DATA_WIDTH = 98,
   parameter int                      COMMAND_BIT_LEN  = 2,
   parameter logic [TABLE_ENTRY_SIZE:0] INIT_OCCUPIED  = '0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [COMMAND_BIT_LEN-1:0]  cmd,
   input  logic [INDEX_BIT_LEN-1:0]    cmd_pred,
   input  logic [INDEX_BIT_LEN-1:0]    cmd_ruleID,
   input  logic [31:0]                 cmd_srcIP,
   input  logic [31:0]                 cmd_dstIP,
   input  logic [ENTRY_DATA_WIDTH-1:0] rd_data,
   output logic                        we,
   output logic [ENTRY_DATA_WIDTH-1:0] din,
   output logic [INDEX_BIT_LEN:0]      search_index,
   output logic                        done,
   output logic [1:0]                  status,
   output logic [INDEX_BIT_LEN-1:0]    slot
);

   localparam int NUM_ENTRIES = TABLE_ENTRY_SIZE + 1;
   localparam int NEXT_LSB    = ENTRY_DATA_WIDTH - INDEX_BIT_LEN;
   localparam int RULE_LSB    = NEXT_LSB - INDEX_BIT_LEN;
   localparam int DST_LSB     = 38;
   localparam int SRC_LSB     = 0;

   localparam logic [INDEX_BIT_LEN-1:0]   NULL_IDX   = '1;
   localparam logic [INDEX_BIT_LEN-1:0]   MAX_IDX    = INDEX_BIT_LEN'(TABLE_ENTRY_SIZE);
   localparam logic [COMMAND_BIT_LEN-1:0] CMD_NOP    = COMMAND_BIT_LEN'(0);
   localparam logic [COMMAND_BIT_LEN-1:0] CMD_INSERT = COMMAND_BIT_LEN'(1);
   localparam logic [COMMAND_BIT_LEN-1:0] CMD_DELETE = COMMAND_BIT_LEN'(2);
   localparam logic [1:0] ST_OK = 2'b00, ST_FULL = 2'b01, ST_NOTFOUND = 2'b10, ST_BADCMD = 2'b11;

   typedef enum logic [3:0] {
      IDLE, RD_PRED, CAP_PRED, RD_TGT, CAP_TGT, WR_NEW, WR_PRED, CLR_TGT, DONE
   } state_t;

   state_t                        state_reg, state_next;
   logic                          is_insert_reg, is_insert_next;
   logic [INDEX_BIT_LEN-1:0]      pred_reg, pred_next;
   logic [INDEX_BIT_LEN-1:0]      rule_reg, rule_next;
   logic [31:0]                   src_reg, src_next;
   logic [31:0]                   dst_reg, dst_next;
   logic [INDEX_BIT_LEN-1:0]      slot_reg, slot_next;
   logic [ENTRY_DATA_WIDTH-1:0]   pred_entry_reg, pred_entry_next;
   logic [INDEX_BIT_LEN-1:0]      tgt_next_reg, tgt_next_next;
   logic [1:0]                    status_reg, status_next;
   logic [NUM_ENTRIES-1:0]        bitmap_reg, bitmap_next;

   logic [INDEX_BIT_LEN-1:0]      rd_next;
   logic [NUM_ENTRIES-1:0]        slot_hit, tgt_hit;
   logic                          free_found, tgt_occupied;
   logic [INDEX_BIT_LEN-1:0]      free_idx;

   assign rd_next = rd_data[NEXT_LSB +: INDEX_BIT_LEN];

   // One-hot decode of the working slot and of the looked-up successor.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_hit
         assign slot_hit[gi] = (slot_reg == INDEX_BIT_LEN'(gi));
         assign tgt_hit[gi]  = (rd_next  == INDEX_BIT_LEN'(gi));
      end
   endgenerate

   assign tgt_occupied = |(tgt_hit & bitmap_reg);

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (!bitmap_reg[i]) begin
            free_found = 1'b1;
            free_idx   = INDEX_BIT_LEN'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         is_insert_reg  <= 1'b0;
         pred_reg       <= '0;
         rule_reg       <= '0;
         src_reg        <= '0;
         dst_reg        <= '0;
         slot_reg       <= '0;
         pred_entry_reg <= '0;
         tgt_next_reg   <= '0;
         status_reg     <= '0;
         bitmap_reg     <= INIT_OCCUPIED;
      end else begin
         state_reg      <= state_next;
         is_insert_reg  <= is_insert_next;
         pred_reg       <= pred_next;
         rule_reg       <= rule_next;
         src_reg        <= src_next;
         dst_reg        <= dst_next;
         slot_reg       <= slot_next;
         pred_entry_reg <= pred_entry_next;
         tgt_next_reg   <= tgt_next_next;
         status_reg     <= status_next;
         bitmap_reg     <= bitmap_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      is_insert_next  = is_insert_reg;
      pred_next       = pred_reg;
      rule_next       = rule_reg;
      src_next        = src_reg;
      dst_next        = dst_reg;
      slot_next       = slot_reg;
      pred_entry_next = pred_entry_reg;
      tgt_next_next   = tgt_next_reg;
      status_next     = status_reg;
      bitmap_next     = bitmap_reg;
      cmd_ready       = 1'b0;
      we              = 1'b0;
      din             = '0;
      search_index    = '0;
      done            = 1'b0;

      case (state_reg)
         IDLE: begin
            cmd_ready = rst_n;
            if (cmd_valid && cmd_ready && cmd != CMD_NOP) begin
               is_insert_next = (cmd == CMD_INSERT);
               pred_next      = cmd_pred;
               rule_next      = cmd_ruleID;
               src_next       = cmd_srcIP;
               dst_next       = cmd_dstIP;
               slot_next      = free_idx;
               if ((cmd != CMD_INSERT && cmd != CMD_DELETE) || cmd_pred > MAX_IDX) begin
                  status_next = ST_BADCMD;
                  state_next  = DONE;
               end else if (cmd == CMD_INSERT && !free_found) begin
                  status_next = ST_FULL;
                  state_next  = DONE;
               end else begin
                  status_next = ST_OK;
                  state_next  = RD_PRED;
               end
            end
         end
         RD_PRED: begin
            search_index = {1'b0, pred_reg};
            state_next   = CAP_PRED;
         end
         CAP_PRED: begin
            search_index    = {1'b0, pred_reg};
            pred_entry_next = rd_data;
            if (is_insert_reg) begin
               state_next = WR_NEW;
            end else begin
               slot_next = rd_next;
               // A self-looping predecessor is treated as an empty chain.
               if (rd_next == NULL_IDX || !tgt_occupied || rd_next == pred_reg) begin
                  status_next = ST_NOTFOUND;
                  state_next  = DONE;
               end else begin
                  state_next = RD_TGT;
               end
            end
         end
         RD_TGT: begin
            search_index = {1'b0, slot_reg};
            state_next   = CAP_TGT;
         end
         CAP_TGT: begin
            search_index  = {1'b0, slot_reg};
            tgt_next_next = rd_next;
            state_next    = WR_PRED;
         end
         WR_NEW: begin
            we                                = 1'b1;
            search_index                      = {1'b0, slot_reg};
            din[NEXT_LSB +: INDEX_BIT_LEN]    = pred_entry_reg[NEXT_LSB +: INDEX_BIT_LEN];
            din[RULE_LSB +: INDEX_BIT_LEN]    = rule_reg;
            din[DST_LSB +: 32]                = dst_reg;
            din[SRC_LSB +: 32]                = src_reg;
            bitmap_next                       = bitmap_reg | slot_hit;
            state_next                        = WR_PRED;
         end
         WR_PRED: begin
            we                             = 1'b1;
            search_index                   = {1'b0, pred_reg};
            din                            = pred_entry_reg;
            din[NEXT_LSB +: INDEX_BIT_LEN] = is_insert_reg ? slot_reg : tgt_next_reg;
            state_next                     = is_insert_reg ? DONE : CLR_TGT;
         end
         CLR_TGT: begin
            we           = 1'b1;
            search_index = {1'b0, slot_reg};
            bitmap_next  = bitmap_reg & ~slot_hit;
            state_next   = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign status = done ? status_reg : 2'b00;
   assign slot   = done ? slot_reg : '0;

endmodule
